// File: rtl/pipe_ctrl_sequencer_pkg.sv
// Shared encodings and the decoded control bundle for the pipeline control sequencer.
package pipe_ctrl_sequencer_pkg;

   localparam int unsigned RA_W_DEFAULT = 5;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;
   localparam logic [1:0] RES_IMM = 2'b11;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
      logic [2:0] alu_control;
      logic       alu_src;
      logic       jump;
      logic       jalr;
      logic       branch;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_ctrl_sequencer_if.sv
// Decoder/datapath <-> control sequencer bundle. Perf counters present only with PIPE_PERF_EN.
interface pipe_ctrl_sequencer_if #(
   parameter int unsigned RA_W = 5
`ifdef PIPE_PERF_EN
   ,
   parameter int unsigned CNT_W = 32
`endif
);
   logic            RegWriteD;
   logic [1:0]      ResultSrcD;
   logic            MemWriteD;
   logic [2:0]      ALUControlD;
   logic            ALUSrcD;
   logic            JumpD;
   logic            JalrD;
   logic            BranchD;
   logic [RA_W-1:0] Rs1D;
   logic [RA_W-1:0] Rs2D;
   logic [RA_W-1:0] RdD;
   logic            ZeroE;

   logic            RegWriteE, RegWriteM, RegWriteW;
   logic [1:0]      ResultSrcE, ResultSrcM, ResultSrcW;
   logic            MemWriteE, MemWriteM;
   logic [2:0]      ALUControlE;
   logic            ALUSrcE;
   logic            JalrE;
   logic [RA_W-1:0] RdE, RdM, RdW;
   logic            PCSrcE;
   logic            StallF, StallD;
   logic            FlushD, FlushE;
   logic [1:0]      ForwardAE, ForwardBE;
`ifdef PIPE_PERF_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
`endif

   modport master (
      output RegWriteD, ResultSrcD, MemWriteD, ALUControlD, ALUSrcD, JumpD, JalrD, BranchD,
      output Rs1D, Rs2D, RdD, ZeroE,
      input  RegWriteE, RegWriteM, RegWriteW, ResultSrcE, ResultSrcM, ResultSrcW,
      input  MemWriteE, MemWriteM, ALUControlE, ALUSrcE, JalrE, RdE, RdM, RdW,
      input  PCSrcE, StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE
`ifdef PIPE_PERF_EN
      ,
      input  stall_cnt, flush_cnt
`endif
   );

   modport slave (
      input  RegWriteD, ResultSrcD, MemWriteD, ALUControlD, ALUSrcD, JumpD, JalrD, BranchD,
      input  Rs1D, Rs2D, RdD, ZeroE,
      output RegWriteE, RegWriteM, RegWriteW, ResultSrcE, ResultSrcM, ResultSrcW,
      output MemWriteE, MemWriteM, ALUControlE, ALUSrcE, JalrE, RdE, RdM, RdW,
      output PCSrcE, StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE
`ifdef PIPE_PERF_EN
      ,
      output stall_cnt, flush_cnt
`endif
   );

endinterface

// File: rtl/pipe_ctrl_sequencer_hazard_detect.sv
// Combinational load-use stall, E-stage redirect and ALU operand forwarding selects.
module pipe_ctrl_sequencer_hazard_detect
   import pipe_ctrl_sequencer_pkg::*;
#(
   parameter int unsigned RA_W = RA_W_DEFAULT
) (
   input  logic [1:0]      result_src_e,
   input  logic [RA_W-1:0] rd_e,
   input  logic [RA_W-1:0] rs1_d,
   input  logic [RA_W-1:0] rs2_d,
   input  logic            jump_e,
   input  logic            branch_e,
   input  logic            zero_e,
   input  logic [RA_W-1:0] rs1_e,
   input  logic [RA_W-1:0] rs2_e,
   input  logic            reg_write_m,
   input  logic [RA_W-1:0] rd_m,
   input  logic            reg_write_w,
   input  logic [RA_W-1:0] rd_w,
   output logic            lw_stall,
   output logic            pc_src,
   output logic [1:0]      forward_a,
   output logic [1:0]      forward_b
);

   logic m_live, w_live;

   assign lw_stall = (result_src_e == RES_MEM) && (rd_e != '0) &&
                     ((rd_e == rs1_d) || (rd_e == rs2_d));
   assign pc_src   = jump_e || (branch_e && zero_e);

   // x0 writes never count as producers.
   assign m_live = reg_write_m && (rd_m != '0);
   assign w_live = reg_write_w && (rd_w != '0);

   assign forward_a = (m_live && rd_m == rs1_e) ? FWD_M :
                      (w_live && rd_w == rs1_e) ? FWD_W : FWD_RF;
   assign forward_b = (m_live && rd_m == rs2_e) ? FWD_M :
                      (w_live && rd_w == rs2_e) ? FWD_W : FWD_RF;

endmodule

// File: rtl/pipe_ctrl_sequencer.sv
// Carries decoded control through E/M/W and applies stall/flush/forwarding.
// Optional perf counters (stall_cnt, flush_cnt) are built when PIPE_PERF_EN is defined.
module pipe_ctrl_sequencer
   import pipe_ctrl_sequencer_pkg::*;
#(
   parameter int unsigned RA_W = RA_W_DEFAULT
`ifdef PIPE_PERF_EN
   ,
   parameter int unsigned CNT_W = 32
`endif
) (
   input logic                 clk,
   input logic                 rst,
   pipe_ctrl_sequencer_if.slave bus
);

   ctrl_t           ctrl_d, ctrl_e_q;
   logic [RA_W-1:0] rd_e_q, rs1_e_q, rs2_e_q;
   logic            reg_write_m_q, mem_write_m_q;
   logic [1:0]      result_src_m_q;
   logic [RA_W-1:0] rd_m_q;
   logic            reg_write_w_q;
   logic [1:0]      result_src_w_q;
   logic [RA_W-1:0] rd_w_q;
   logic            lw_stall, pc_src, flush_e;
   logic [1:0]      forward_a, forward_b;

   assign ctrl_d = '{reg_write:   bus.RegWriteD,
                     result_src:  bus.ResultSrcD,
                     mem_write:   bus.MemWriteD,
                     alu_control: bus.ALUControlD,
                     alu_src:     bus.ALUSrcD,
                     jump:        bus.JumpD,
                     jalr:        bus.JalrD,
                     branch:      bus.BranchD};

   assign flush_e = lw_stall || pc_src;

   // E takes a bubble on flush; M and W always advance.
   always_ff @(posedge clk) begin
      if (rst || flush_e) begin
         ctrl_e_q <= CTRL_NOP;
         rd_e_q   <= '0;
         rs1_e_q  <= '0;
         rs2_e_q  <= '0;
      end else begin
         ctrl_e_q <= ctrl_d;
         rd_e_q   <= bus.RdD;
         rs1_e_q  <= bus.Rs1D;
         rs2_e_q  <= bus.Rs2D;
      end
      if (rst) begin
         reg_write_m_q  <= 1'b0;
         mem_write_m_q  <= 1'b0;
         result_src_m_q <= RES_ALU;
         rd_m_q         <= '0;
         reg_write_w_q  <= 1'b0;
         result_src_w_q <= RES_ALU;
         rd_w_q         <= '0;
      end else begin
         reg_write_m_q  <= ctrl_e_q.reg_write;
         mem_write_m_q  <= ctrl_e_q.mem_write;
         result_src_m_q <= ctrl_e_q.result_src;
         rd_m_q         <= rd_e_q;
         reg_write_w_q  <= reg_write_m_q;
         result_src_w_q <= result_src_m_q;
         rd_w_q         <= rd_m_q;
      end
   end

   pipe_ctrl_sequencer_hazard_detect #(
      .RA_W (RA_W)
   ) u_hazard (
      .result_src_e (ctrl_e_q.result_src),
      .rd_e         (rd_e_q),
      .rs1_d        (bus.Rs1D),
      .rs2_d        (bus.Rs2D),
      .jump_e       (ctrl_e_q.jump),
      .branch_e     (ctrl_e_q.branch),
      .zero_e       (bus.ZeroE),
      .rs1_e        (rs1_e_q),
      .rs2_e        (rs2_e_q),
      .reg_write_m  (reg_write_m_q),
      .rd_m         (rd_m_q),
      .reg_write_w  (reg_write_w_q),
      .rd_w         (rd_w_q),
      .lw_stall     (lw_stall),
      .pc_src       (pc_src),
      .forward_a    (forward_a),
      .forward_b    (forward_b)
   );

   assign bus.RegWriteE   = ctrl_e_q.reg_write;
   assign bus.ResultSrcE  = ctrl_e_q.result_src;
   assign bus.MemWriteE   = ctrl_e_q.mem_write;
   assign bus.ALUControlE = ctrl_e_q.alu_control;
   assign bus.ALUSrcE     = ctrl_e_q.alu_src;
   assign bus.JalrE       = ctrl_e_q.jalr;
   assign bus.RdE         = rd_e_q;
   assign bus.RegWriteM   = reg_write_m_q;
   assign bus.ResultSrcM  = result_src_m_q;
   assign bus.MemWriteM   = mem_write_m_q;
   assign bus.RdM         = rd_m_q;
   assign bus.RegWriteW   = reg_write_w_q;
   assign bus.ResultSrcW  = result_src_w_q;
   assign bus.RdW         = rd_w_q;
   assign bus.PCSrcE      = pc_src;
   assign bus.StallF      = lw_stall;
   assign bus.StallD      = lw_stall;
   assign bus.FlushD      = pc_src;
   assign bus.FlushE      = flush_e;
   assign bus.ForwardAE   = forward_a;
   assign bus.ForwardBE   = forward_b;

`ifdef PIPE_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (lw_stall) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (pc_src)   flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl_sequencer.sv
// Directed bench for pipe_ctrl_sequencer; the perf-counter scenario runs only with PIPE_PERF_EN.
module tb_pipe_ctrl_sequencer;
   import pipe_ctrl_sequencer_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

`ifdef PIPE_PERF_EN
   pipe_ctrl_sequencer_if #(.RA_W(5), .CNT_W(4)) bus ();
   pipe_ctrl_sequencer #(.RA_W(5), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
   pipe_ctrl_sequencer_if #(.RA_W(5)) bus ();
   pipe_ctrl_sequencer #(.RA_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   always #5 clk = ~clk;

   function automatic logic [39:0] all_outs();
      return {bus.RegWriteE, bus.RegWriteM, bus.RegWriteW, bus.ResultSrcE, bus.ResultSrcM,
              bus.ResultSrcW, bus.MemWriteE, bus.MemWriteM, bus.ALUControlE, bus.ALUSrcE,
              bus.JalrE, bus.RdE, bus.RdM, bus.RdW, bus.PCSrcE, bus.StallF, bus.StallD,
              bus.FlushD, bus.FlushE, bus.ForwardAE, bus.ForwardBE};
   endfunction

   task automatic set_d(input logic rw, input logic [1:0] res, input logic mw,
                        input logic [2:0] alu, input logic asrc, input logic j,
                        input logic jr, input logic br,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
      bus.RegWriteD = rw;  bus.ResultSrcD = res; bus.MemWriteD = mw;
      bus.ALUControlD = alu; bus.ALUSrcD = asrc; bus.JumpD = j;
      bus.JalrD = jr; bus.BranchD = br;
      bus.Rs1D = r1; bus.Rs2D = r2; bus.RdD = rd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_add(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
      set_d(1'b1, RES_ALU, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, r1, r2, rd);
      step();
   endtask

   task automatic issue_lw(input logic [4:0] rd);
      set_d(1'b1, RES_MEM, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd0, rd);
      step();
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         rst = 1'b1;
         set_d(1'($urandom), 2'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom),
               5'($urandom));
         bus.ZeroE = 1'($urandom);
         step();
         n_cmp++;
         if (all_outs() !== 40'h0) begin
            n_err++;
            $display("FAIL reset_outs[%0d]: got %h want 0", i, all_outs());
         end
      end
      rst = 1'b0;
      bus.ZeroE = 1'b0;
      set_d(1'b1, RES_ALU, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd7);
      step();
      n_cmp++;
      if ({bus.RegWriteE, bus.ResultSrcE, bus.ALUControlE, bus.RdE, bus.RegWriteM}
          !== {1'b1, RES_ALU, 3'b010, 5'd7, 1'b0}) begin
         n_err++;
         $display("FAIL first_e: got %h want %h",
                  {bus.RegWriteE, bus.ResultSrcE, bus.ALUControlE, bus.RdE, bus.RegWriteM},
                  {1'b1, RES_ALU, 3'b010, 5'd7, 1'b0});
      end
   endtask

   task automatic test_reset_mid();
      set_d(1'b0, RES_ALU, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 5'd3, 5'd0);
      step();
      n_cmp++;
      if (bus.MemWriteE !== 1'b1) begin
         n_err++;
         $display("FAIL store_in_e: got %b want 1", bus.MemWriteE);
      end
      rst = 1'b1;
      step();
      n_cmp++;
      if (all_outs() !== 40'h0) begin
         n_err++;
         $display("FAIL reset_mid: got %h want 0", all_outs());
      end
      rst = 1'b0;
      set_d(1'b0, RES_ALU, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      step();
   endtask

   task automatic test_load_use();
      issue_lw(5'd5);
      set_d(1'b1, RES_ALU, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd6, 5'd8);
      #1;
      n_cmp++;
      if ({bus.StallF, bus.StallD, bus.FlushE, bus.FlushD} !== 4'b1110) begin
         n_err++;
         $display("FAIL lw_stall: got %b want 1110",
                  {bus.StallF, bus.StallD, bus.FlushE, bus.FlushD});
      end
      step();
      n_cmp++;
      if ({bus.RegWriteE, bus.ResultSrcE, bus.RdE, bus.StallF, bus.FlushE} !== 10'h0) begin
         n_err++;
         $display("FAIL lw_bubble: got %h want 0",
                  {bus.RegWriteE, bus.ResultSrcE, bus.RdE, bus.StallF, bus.FlushE});
      end
      n_cmp++;
      if ({bus.RegWriteM, bus.ResultSrcM, bus.RdM} !== {1'b1, RES_MEM, 5'd5}) begin
         n_err++;
         $display("FAIL lw_in_m: got %h want %h", {bus.RegWriteM, bus.ResultSrcM, bus.RdM},
                  {1'b1, RES_MEM, 5'd5});
      end
      step();
      n_cmp++;
      if ({bus.ForwardAE, bus.ForwardBE, bus.RdE} !== {FWD_W, FWD_RF, 5'd8}) begin
         n_err++;
         $display("FAIL lw_fwd: got %h want %h", {bus.ForwardAE, bus.ForwardBE, bus.RdE},
                  {FWD_W, FWD_RF, 5'd8});
      end
      // lw to x0 is not a hazard.
      issue_lw(5'd0);
      set_d(1'b1, RES_ALU, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd9);
      #1;
      n_cmp++;
      if (bus.StallD !== 1'b0) begin
         n_err++;
         $display("FAIL lw_x0: got %b want 0", bus.StallD);
      end
      issue_lw(5'd6);
      set_d(1'b1, RES_ALU, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd6, 5'd9);
      #1;
      n_cmp++;
      if ({bus.StallF, bus.FlushE} !== 2'b11) begin
         n_err++;
         $display("FAIL lw_rs2: got %b want 11", {bus.StallF, bus.FlushE});
      end
      step();
      step();
   endtask

   task automatic test_forward();
      issue_add(5'd0, 5'd0, 5'd3);
      issue_add(5'd0, 5'd0, 5'd3);
      issue_add(5'd3, 5'd3, 5'd9);
      n_cmp++;
      if ({bus.ForwardAE, bus.ForwardBE} !== {FWD_M, FWD_M}) begin
         n_err++;
         $display("FAIL fwd_m_prio: got %b want 1010", {bus.ForwardAE, bus.ForwardBE});
      end
      issue_add(5'd0, 5'd0, 5'd3);
      issue_add(5'd0, 5'd0, 5'd0);
      issue_add(5'd3, 5'd0, 5'd9);
      n_cmp++;
      if ({bus.ForwardAE, bus.ForwardBE} !== {FWD_W, FWD_RF}) begin
         n_err++;
         $display("FAIL fwd_rdm0: got %b want 0100", {bus.ForwardAE, bus.ForwardBE});
      end
      issue_add(5'd0, 5'd0, 5'd0);
      issue_add(5'd0, 5'd0, 5'd0);
      issue_add(5'd0, 5'd0, 5'd9);
      n_cmp++;
      if ({bus.ForwardAE, bus.ForwardBE} !== {FWD_RF, FWD_RF}) begin
         n_err++;
         $display("FAIL fwd_x0: got %b want 0000", {bus.ForwardAE, bus.ForwardBE});
      end
      issue_add(5'd0, 5'd0, 5'd4);
      set_d(1'b0, RES_ALU, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd4);
      step();
      issue_add(5'd4, 5'd7, 5'd9);
      n_cmp++;
      if ({bus.ForwardAE, bus.ForwardBE} !== {FWD_W, FWD_RF}) begin
         n_err++;
         $display("FAIL fwd_no_rw_m: got %b want 0100", {bus.ForwardAE, bus.ForwardBE});
      end
   endtask

   task automatic test_branch();
      set_d(1'b0, RES_ALU, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd0);
      step();
      bus.ZeroE = 1'b1;
      set_d(1'b1, RES_ALU, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd10);
      #1;
      n_cmp++;
      if ({bus.PCSrcE, bus.FlushD, bus.FlushE, bus.StallF} !== 4'b1110) begin
         n_err++;
         $display("FAIL br_taken: got %b want 1110",
                  {bus.PCSrcE, bus.FlushD, bus.FlushE, bus.StallF});
      end
      step();
      n_cmp++;
      if ({bus.RegWriteE, bus.RdE, bus.PCSrcE} !== 7'h0) begin
         n_err++;
         $display("FAIL br_bubble: got %h want 0", {bus.RegWriteE, bus.RdE, bus.PCSrcE});
      end
      bus.ZeroE = 1'b0;
      set_d(1'b0, RES_ALU, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd0);
      step();
      set_d(1'b1, RES_ALU, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd10);
      #1;
      n_cmp++;
      if ({bus.PCSrcE, bus.FlushD, bus.FlushE} !== 3'b000) begin
         n_err++;
         $display("FAIL br_not_taken: got %b want 000", {bus.PCSrcE, bus.FlushD, bus.FlushE});
      end
      step();
      n_cmp++;
      if ({bus.RegWriteE, bus.RdE} !== {1'b1, 5'd10}) begin
         n_err++;
         $display("FAIL br_fallthru: got %h want %h", {bus.RegWriteE, bus.RdE}, {1'b1, 5'd10});
      end
   endtask

   task automatic test_jump();
      bus.ZeroE = 1'b0;
      set_d(1'b1, RES_PC4, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 5'd0, 5'd1);
      step();
      set_d(1'b1, RES_ALU, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd11);
      #1;
      n_cmp++;
      if ({bus.PCSrcE, bus.FlushD, bus.FlushE, bus.JalrE} !== 4'b1111) begin
         n_err++;
         $display("FAIL jalr_z0: got %b want 1111",
                  {bus.PCSrcE, bus.FlushD, bus.FlushE, bus.JalrE});
      end
      bus.ZeroE = 1'b1;
      #1;
      n_cmp++;
      if (bus.PCSrcE !== 1'b1) begin
         n_err++;
         $display("FAIL jalr_z1: got %b want 1", bus.PCSrcE);
      end
      step();
      n_cmp++;
      if ({bus.RegWriteM, bus.ResultSrcM, bus.RdM, bus.RegWriteE}
          !== {1'b1, RES_PC4, 5'd1, 1'b0}) begin
         n_err++;
         $display("FAIL jalr_m: got %h want %h",
                  {bus.RegWriteM, bus.ResultSrcM, bus.RdM, bus.RegWriteE},
                  {1'b1, RES_PC4, 5'd1, 1'b0});
      end
      bus.ZeroE = 1'b0;
   endtask

`ifdef PIPE_PERF_EN
   task automatic test_perf();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_cmp++;
      if ({bus.stall_cnt, bus.flush_cnt} !== 8'h00) begin
         n_err++;
         $display("FAIL perf_rst: got %h want 00", {bus.stall_cnt, bus.flush_cnt});
      end
      for (int i = 0; i < 17; i++) begin
         issue_lw(5'd5);
         set_d(1'b1, RES_ALU, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd8);
         step();
         step();
      end
      n_cmp++;
      if ({bus.stall_cnt, bus.flush_cnt} !== 8'h10) begin
         n_err++;
         $display("FAIL perf_wrap: got %h want 10", {bus.stall_cnt, bus.flush_cnt});
      end
      set_d(1'b1, RES_PC4, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd1);
      step();
      set_d(1'b0, RES_ALU, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      step();
      n_cmp++;
      if ({bus.stall_cnt, bus.flush_cnt} !== 8'h11) begin
         n_err++;
         $display("FAIL perf_flush: got %h want 11", {bus.stall_cnt, bus.flush_cnt});
      end
      issue_lw(5'd5);
      set_d(1'b1, RES_ALU, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd8);
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_cmp++;
      if ({bus.stall_cnt, bus.flush_cnt} !== 8'h00) begin
         n_err++;
         $display("FAIL perf_rst_mid: got %h want 00", {bus.stall_cnt, bus.flush_cnt});
      end
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.ZeroE = 1'b0;
      set_d(1'b0, RES_ALU, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      test_reset();
      test_reset_mid();
      test_load_use();
      test_forward();
      test_branch();
      test_jump();
`ifdef PIPE_PERF_EN
      test_perf();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
